// File: rtl/cva5_types.sv
// Shared CVA5 core types: configuration, instruction IDs, fetch metadata and the decode packet.
package cva5_types;

  typedef struct packed {
    logic [31:0] reset_vector;
    logic        include_fetch_buffer;
  } cpu_config_t;

  localparam cpu_config_t EXAMPLE_CONFIG = '{
    reset_vector:         32'h8000_0000,
    include_fetch_buffer: 1'b1
  };

  localparam int LOG2_MAX_IDS = 3;
  typedef logic [LOG2_MAX_IDS-1:0] id_t;

  typedef enum logic [4:0] {
    INST_ADDR_MISSALIGNED = 5'd0,
    INST_ACCESS_FAULT     = 5'd1,
    ILLEGAL_INST          = 5'd2,
    INST_PAGE_FAULT       = 5'd12
  } exception_code_t;

  typedef struct packed {
    logic            ok;
    exception_code_t error_code;
  } fetch_metadata_t;

  // valid is the top field so the packet can be built as {valid, stored_entry}
  typedef struct packed {
    logic            valid;
    logic [31:0]     pc;
    logic [31:0]     instruction;
    fetch_metadata_t fetch_metadata;
    id_t             id;
  } decode_packet_t;

endpackage

// File: rtl/cva5_fifo_lutram.sv
// Distributed-RAM style FIFO storage: one synchronous write port, one asynchronous read port.
// Zero-cycle read latency; no flow control here, the owner manages pointers and occupancy.
module cva5_fifo_lutram #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     write_en,
  input  logic [$clog2(DEPTH)-1:0] write_addr,
  input  logic [WIDTH-1:0]         write_data,
  input  logic [$clog2(DEPTH)-1:0] read_addr,
  output logic [WIDTH-1:0]         read_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (write_en) mem[write_addr] <= write_data;
  end

  assign read_data = mem[read_addr];

endmodule

// File: rtl/fetch_instruction_buffer.sv
// Fetch-to-decode instruction FIFO; push visible at decode one cycle later, head read combinationally.
// fetch_ready depends only on registered count, so a full buffer stalls fetch one cycle past the freeing pop.
module fetch_instruction_buffer
  import cva5_types::*;
#(
  parameter cpu_config_t CONFIG = EXAMPLE_CONFIG,
  parameter int          DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       fetch_valid,
  input  logic [31:0]                fetch_pc,
  input  logic [31:0]                fetch_instruction,
  input  fetch_metadata_t            fetch_metadata,
  input  id_t                        fetch_id,
  output logic                       fetch_ready,
  output decode_packet_t             decode,
  input  logic                       decode_advance,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = $clog2(DEPTH+1);
  localparam int ENTRY_W = 64 + $bits(fetch_metadata_t) + $bits(id_t);

  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [CNT_W-1:0]   count;
  logic               head_valid;
  logic               push;
  logic               pop;
  logic [ENTRY_W-1:0] write_data;
  logic [ENTRY_W-1:0] read_data;

  logic unused_config;
  assign unused_config = ^CONFIG;

  assign fetch_ready = (count != CNT_W'(DEPTH));
  assign head_valid  = (count != '0);
  assign push        = fetch_valid & fetch_ready & ~flush & ~rst;
  assign pop         = decode_advance & head_valid & ~flush & ~rst;
  assign occupancy   = count;

  // Pointers wrap naturally since DEPTH is a power of two; full/empty come from count alone
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign write_data = {fetch_pc, fetch_instruction, fetch_metadata, fetch_id};

  cva5_fifo_lutram #(
    .WIDTH(ENTRY_W),
    .DEPTH(DEPTH)
  ) entries (
    .clk       (clk),
    .write_en  (push),
    .write_addr(wr_ptr),
    .write_data(write_data),
    .read_addr (rd_ptr),
    .read_data (read_data)
  );

  always_comb begin
    decode = decode_packet_t'({head_valid, read_data});
  end

endmodule
